ex_hazard_ctrl: RTL

//  Hazard and forwarding scheduler for the 5-stage EX datapath. Keeps a shadow copy of

---
 rtl/ex_hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard scheduler. It keeps shadow destination info for EX/MEM/WB,
// drives the ALU operand forward selects and raises the one-cycle load-use stall.

module ex_hazard_fwd_sel #(
  parameter int REG_W = 5
) (
  input  logic             ex_v,
  input  logic             ex_use,
  input  logic [REG_W-1:0] src,
  input  logic             mem_v,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] mem_wr_reg,
  input  logic [1:0]       mem_wr_src,
  input  logic             wb_v,
  input  logic             wb_wr_en,
  input  logic [REG_W-1:0] wb_wr_reg,
  input  logic [1:0]       wb_wr_src,
  output logic [2:0]       sel
);
  logic mem_hit, wb_hit;

  assign mem_hit = mem_v & mem_wr_en & (mem_wr_reg == src) & (src != '0);
  assign wb_hit  = wb_v  & wb_wr_en  & (wb_wr_reg  == src) & (src != '0);

  // A load never sits in MEM opposite its consumer (stall bubble), so MEM only
  // distinguishes ExtImm from ALU result.
  always_comb begin
    sel = 3'd0;
    if (ex_v && ex_use) begin
      if (mem_hit)
        sel = (mem_wr_src == 2'd1) ? 3'd1 : 3'd2;
      else if (wb_hit) begin
        case (wb_wr_src)
          2'd1:    sel = 3'd3;
          2'd2:    sel = 3'd5;
          default: sel = 3'd4;
        endcase
      end
    end
  end
endmodule

module ex_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [1:0]       id_wr_src,
  output logic             stall,
  output logic [2:0]       alua_fwd_ctr,
  output logic [2:0]       alub_fwd_ctr,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int STAGES  = 2;  // vld_pipe[0]=EX, [1]=MEM, [2]=WB
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic [1:0]       wr_src;
  } dst_t;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } src_t;

  logic [STAGES:0]                vld_pipe;
  dst_t [STAGES:0]                dst_pipe;
  src_t                           ex_src;
  dst_t                           id_dst;
  src_t                           id_src;
  logic [NUM_OPS-1:0][REG_W-1:0]  op_reg;
  logic [NUM_OPS-1:0]             op_use;
  logic [NUM_OPS-1:0][2:0]        op_sel;
  logic                           ex_load;

  assign id_dst = '{wr_en: id_wr_en, wr_reg: id_wr_reg, wr_src: id_wr_src};
  assign id_src = '{rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt};

  assign ex_load = vld_pipe[0] & dst_pipe[0].wr_en & (dst_pipe[0].wr_src == 2'd2) &
                   (dst_pipe[0].wr_reg != '0);

  assign stall = id_valid & ~flush & ex_load &
                 ((id_use_rs & (id_rs == dst_pipe[0].wr_reg)) |
                  (id_use_rt & (id_rt == dst_pipe[0].wr_reg)));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], id_valid & ~stall & ~flush};
      dst_pipe <= {dst_pipe[STAGES-1:0], id_dst};
      ex_src   <= id_src;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign op_reg = {ex_src.rt, ex_src.rs};
  assign op_use = {ex_src.use_rt, ex_src.use_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    ex_hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
      .ex_v       (vld_pipe[0]),
      .ex_use     (op_use[g]),
      .src        (op_reg[g]),
      .mem_v      (vld_pipe[1]),
      .mem_wr_en  (dst_pipe[1].wr_en),
      .mem_wr_reg (dst_pipe[1].wr_reg),
      .mem_wr_src (dst_pipe[1].wr_src),
      .wb_v       (vld_pipe[2]),
      .wb_wr_en   (dst_pipe[2].wr_en),
      .wb_wr_reg  (dst_pipe[2].wr_reg),
      .wb_wr_src  (dst_pipe[2].wr_src),
      .sel        (op_sel[g])
    );
  end

  assign alua_fwd_ctr = op_sel[0];
  assign alub_fwd_ctr = op_sel[1];
endmodule
